prio_event_fifo: RTL

//   Downstream consumer of the 16-input priority encoder output (8-bit code).

---
 rtl/prio_pkg.sv | 15 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/prio_event_fifo.sv | 90 +++++++++
 3 files changed

// File: rtl/prio_pkg.sv
// Shared constants and the event record type for the priority-event FIFO.
package prio_pkg;

  localparam int CODE_W = 8;
  localparam int TS_W   = 8;

  localparam logic [CODE_W-1:0] NONE_CODE = 8'hF0;

  // One buffered event: timestamp in the upper bits, encoder code below.
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [CODE_W-1:0] code;
  } prio_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH register FIFO with an extra pointer MSB for full/empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic [AW:0] w_count;
  logic        w_we;
  logic        w_re;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign count   = w_count;
  assign empty   = (w_count == '0);
  assign full    = (w_count == (AW+1)'(DEPTH));

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_we = push && !clr && (!full || pop);
  assign w_re = pop  && !clr && !empty;

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush returns both pointers to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write at the tail slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/prio_event_fifo.sv
// Timestamps every change of the priority-encoder code and buffers it for a
// slow valid/ready consumer; a sticky flag records any dropped event.
module prio_event_fifo
  import prio_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [CODE_W-1:0] NONE_VAL  = NONE_CODE,
  parameter bit                SKIP_NONE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   clr,
  input  logic [CODE_W-1:0]      code_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [CODE_W-1:0]      out_code,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  logic [TS_W-1:0]   r_ts;
  logic [CODE_W-1:0] r_prev_code;
  logic              r_overflow;

  logic              w_ev;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  prio_event_t       w_din;
  prio_event_t       w_dout;

  assign w_ev   = ena && (code_in != r_prev_code);
  assign w_push = w_ev && !(SKIP_NONE && (code_in == NONE_VAL));
  assign w_pop  = !w_empty && out_ready;
  assign w_din  = '{ts: r_ts, code: code_in};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W + CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  // Free-running timestamp, gated by ena and zeroed by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_ts <= '0;
    else if (clr) r_ts <= '0;
    else if (ena) r_ts <= r_ts + 1'b1;
  end

  // Last code seen; a flush forgets it so the next capture compares with "none".
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_prev_code <= NONE_VAL;
    else if (clr)  r_prev_code <= NONE_VAL;
    else if (w_ev) r_prev_code <= code_in;
  end

  // Sticky drop flag: set when an event arrives with no room and no pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_overflow <= 1'b0;
    else if (clr)                        r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
  end

  // Head presentation; fields read as zero while the FIFO is empty.
  always_comb begin
    out_valid = !w_empty;
    out_code  = '0;
    out_ts    = '0;
    if (!w_empty) begin
      out_code = w_dout.code;
      out_ts   = w_dout.ts;
    end
  end

  assign overflow = r_overflow;

endmodule
